fifo_rd_drain: RTL and testbench



---
 rtl/fifo_rd_drain.sv | 138 +++++++++++++
 tb/tb_fifo_rd_drain.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pops a programmed number of words from a FIFO with one-cycle read
// latency and presents them on a valid/ready stream through a 3-entry skid buffer.
module fifo_rd_drain #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            burst_len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            words_read,
    output logic                  err_underflow
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            issue_left_q, issue_left_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] buf_q [3];
    logic [FIFO_WIDTH-1:0] buf_d [3];
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [7:0]            words_read_q, words_read_d;
    logic                  err_q, err_d;

    logic       start_acc;
    logic       push;
    logic       pop;
    logic       retry;
    logic [2:0] occupancy;
    logic [1:0] wr_idx;

    always_comb begin
        start_acc  = (state_q == StIdle) && start;
        occupancy  = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
        fifo_rd_en = (state_q == StRun) && (issue_left_q != 8'd0) && !fifo_empty && !abort
                     && (occupancy < 3'd3);
        m_valid    = (buf_cnt_q != 2'd0);
        m_data     = buf_q[0];
        pop        = m_valid && m_ready;
        push       = inflight_q && !fifo_underflow;
        // A lost read is only re-issued while still running; after abort it is simply dropped.
        retry      = inflight_q && fifo_underflow && (state_q == StRun);
        busy       = (state_q == StRun) || (state_q == StFlush);
        done       = (state_q == StDone);
        words_read    = words_read_q;
        err_underflow = err_q;
    end

    always_comb begin
        inflight_d = fifo_rd_en;

        if (start_acc) begin
            issue_left_d = burst_len;
        end else begin
            issue_left_d = issue_left_q - {7'd0, fifo_rd_en} + {7'd0, retry};
        end

        buf_d = buf_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        wr_idx = buf_cnt_q - {1'b0, pop};
        if (push) begin
            buf_d[wr_idx] = fifo_data_out;
        end
        buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};

        if (start_acc) begin
            words_read_d = 8'd0;
        end else if (pop && (words_read_q != 8'hff)) begin
            words_read_d = words_read_q + 8'd1;
        end else begin
            words_read_d = words_read_q;
        end

        err_d = start_acc ? 1'b0 : (err_q || (inflight_q && fifo_underflow));

        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (burst_len != 8'd0) ? StRun : StDone;
                end
            end
            // Hold RUN while the last read is in flight so an underflow on it can still retry.
            StRun: begin
                if (abort || ((issue_left_q == 8'd0) && !inflight_q)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!inflight_q && (buf_cnt_d == 2'd0)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            issue_left_q <= 8'd0;
            inflight_q   <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            buf_q[2]     <= '0;
            buf_cnt_q    <= 2'd0;
            words_read_q <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_left_q <= issue_left_d;
            inflight_q   <= inflight_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            words_read_q <= words_read_d;
            err_q        <= err_d;
            assert ((occupancy <= 3'd3) && (FIFO_DEPTH != 0));
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: a behavioural FIFO feeds the engine and a negedge monitor
// records accepted words, read pulses and done pulses for the checks.
module tb_fifo_rd_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  burst_len;
    logic        abort;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [15:0] fifo_data_out;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [7:0]  words_read;
    logic        err_underflow;

    fifo_rd_drain #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .burst_len      (burst_len),
        .abort          (abort),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .words_read     (words_read),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered count/empty, read data one cycle after rd_en.
    logic [15:0] mem [16];
    logic [3:0]  rptr, wptr;
    logic [4:0]  mcnt;
    logic        uf_m;
    logic [15:0] dout_m;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        force_uf;
    logic        rd_ok;

    assign rd_ok          = fifo_rd_en && (mcnt != 5'd0);
    assign fifo_empty     = (mcnt == 5'd0);
    assign fifo_underflow = uf_m | force_uf;
    assign fifo_data_out  = dout_m;

    always @(posedge clk) begin
        if (rst) begin
            rptr <= 4'd0; wptr <= 4'd0; mcnt <= 5'd0; uf_m <= 1'b0; dout_m <= 16'd0;
        end else begin
            uf_m <= fifo_rd_en && (mcnt == 5'd0);
            if (rd_ok) begin
                dout_m <= mem[rptr];
                rptr   <= rptr + 4'd1;
            end
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 4'd1;
            end
            mcnt <= mcnt + {4'd0, wr_en} - {4'd0, rd_ok};
        end
    end

    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int busy_in_done = 0;
    logic [15:0] got[$];
    int acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                acc_cyc.push_back(cyc);
            end
            if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (busy) busy_in_done <= busy_in_done + 1;
            end
        end
    end

    int tests = 0;
    int failures = 0;
    int s, gb, rb, db;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 16'(i);
            cyc_wait(1);
        end
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        cyc_wait(1);
        start     = 1'b0;
        burst_len = 8'hee;
        s         = cyc;
    endtask

    task automatic wait_done(input string tag, input int max);
        int d0 = done_cnt;
        int i = 0;
        while ((done_cnt == d0) && (i < max)) begin
            cyc_wait(1);
            i++;
        end
        cyc_wait(3);
        check(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_words(input string tag, input int base_idx, input logic [15:0] first,
                               input int n);
        check({tag, "_count"}, 32'(got.size() - base_idx), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, (got.size() > base_idx + i) ? 32'(got[base_idx + i])
                                                               : 32'hdeadbeef,
                  32'(first + 16'(i)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; burst_len = 8'd0; abort = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = 16'd0; force_uf = 1'b0;
        cyc_wait(3);
        rst = 1'b0;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words_read", 32'(words_read), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);

        // Basic 5-word burst, consumer always ready.
        push_words(16'h0001, 5);
        cyc_wait(1);
        m_ready = 1'b1;
        gb = got.size(); rb = rd_cnt;
        do_start(8'd5);
        wait_done("t1_done", 40);
        check_words("t1", gb, 16'h0001, 5);
        check("t1_first_valid_lat", 32'(acc_cyc[gb] - s), 32'd2);
        check("t1_back_to_back", 32'(acc_cyc[gb + 4] - acc_cyc[gb]), 32'd4);
        check("t1_words_read", 32'(words_read), 32'd5);
        check("t1_err", 32'(err_underflow), 32'd0);
        check("t1_reads", 32'(rd_cnt - rb), 32'd5);

        // Backpressure: buffer fills to 3 then reads stall.
        m_ready = 1'b0;
        push_words(16'h0010, 8);
        cyc_wait(1);
        gb = got.size(); rb = rd_cnt;
        do_start(8'd8);
        cyc_wait(9);
        check("t2_stall_reads", 32'(rd_cnt - rb), 32'd3);
        check("t2_rd_en_low", 32'(fifo_rd_en), 32'd0);
        check("t2_m_valid", 32'(m_valid), 32'd1);
        check("t2_m_data", 32'(m_data), 32'h0010);
        m_ready = 1'b1;
        wait_done("t2_done", 60);
        check_words("t2", gb, 16'h0010, 8);
        check("t2_words_read", 32'(words_read), 32'd8);
        check("t2_reads", 32'(rd_cnt - rb), 32'd8);

        // FIFO runs dry mid-burst, then refills.
        push_words(16'h0020, 2);
        cyc_wait(1);
        gb = got.size(); rb = rd_cnt;
        do_start(8'd4);
        cyc_wait(5);
        check("t3_stalled_reads", 32'(rd_cnt - rb), 32'd2);
        check("t3_rd_en_low", 32'(fifo_rd_en), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        push_words(16'h0022, 2);
        wait_done("t3_done", 40);
        check_words("t3", gb, 16'h0020, 4);
        check("t3_words_read", 32'(words_read), 32'd4);
        check("t3_reads", 32'(rd_cnt - rb), 32'd4);

        // Abort after two reads issued.
        push_words(16'h0030, 10);
        cyc_wait(1);
        gb = got.size(); rb = rd_cnt;
        do_start(8'd10);
        cyc_wait(2);
        abort = 1'b1;
        cyc_wait(1);
        abort = 1'b0;
        wait_done("t4_done", 40);
        check_words("t4", gb, 16'h0030, 2);
        check("t4_words_read", 32'(words_read), 32'd2);
        check("t4_reads", 32'(rd_cnt - rb), 32'd2);
        rst = 1'b1;
        cyc_wait(2);
        rst = 1'b0;

        // Underflow on the first capture: word 0x40 is lost, one extra read retries.
        push_words(16'h0040, 4);
        cyc_wait(1);
        gb = got.size(); rb = rd_cnt;
        do_start(8'd3);
        cyc_wait(1);
        force_uf = 1'b1;
        cyc_wait(1);
        force_uf = 1'b0;
        wait_done("t5_done", 40);
        check_words("t5", gb, 16'h0041, 3);
        check("t5_err", 32'(err_underflow), 32'd1);
        check("t5_reads", 32'(rd_cnt - rb), 32'd4);
        check("t5_words_read", 32'(words_read), 32'd3);
        cyc_wait(3);
        check("t5_err_sticky", 32'(err_underflow), 32'd1);
        do_start(8'd0);
        check("t5_zero_done", 32'(done), 32'd1);
        check("t5_zero_busy", 32'(busy), 32'd0);
        check("t5_err_cleared", 32'(err_underflow), 32'd0);
        check("t5_zero_words", 32'(words_read), 32'd0);
        cyc_wait(1);
        check("t5_done_one_cycle", 32'(done), 32'd0);

        // Reset mid-burst with two words buffered.
        push_words(16'h0050, 4);
        cyc_wait(1);
        m_ready = 1'b0;
        db = done_cnt;
        do_start(8'd4);
        cyc_wait(2);
        m_ready = 1'b1;
        cyc_wait(1);
        m_ready = 1'b0;
        cyc_wait(1);
        check("t6_pre_buf_cnt", 32'(dut.buf_cnt_q), 32'd2);
        check("t6_pre_m_data", 32'(m_data), 32'h0051);
        check("t6_pre_words_read", 32'(words_read), 32'd1);
        rst = 1'b1;
        cyc_wait(1);
        check("t6_m_valid", 32'(m_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_words_read", 32'(words_read), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        cyc_wait(4);
        check("t6_no_done", 32'(done_cnt - db), 32'd0);

        check("busy_low_in_done", 32'(busy_in_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
